id_pipe: RTL and testbench
==========================

ID_PIPE -- requirements
Module: id_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath/operand width.
REQ-002 Parameter REGADDR_W, default 5, register address width.
REQ-003 Parameter FWD_EN, default 1, 1 = EX/MEM bypass present, 0 = regfile data only.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset; rst=0 forces reset state immediately.
REQ-006 flush  in  1  synchronous kill of held and incoming instruction.
REQ-007 in_valid / in_ready  in / out  1 / 1  upstream handshake.
REQ-008 in_pc, in_inst  in  XLEN / 32  fetched instruction address and word.
REQ-009 reg1_raddr_o, reg2_raddr_o  out  REGADDR_W  combinational regfile read addresses.
REQ-010 reg1_rdata_i, reg2_rdata_i  in  XLEN  regfile read data, same cycle.
REQ-011 ex_we, ex_is_load  in  1  EX-stage write enable and load flag.
REQ-012 ex_waddr / ex_wdata  in  REGADDR_W / XLEN  EX-stage result.
REQ-013 mem_we  in  1; mem_waddr  in  REGADDR_W; mem_wdata  in  XLEN  MEM-stage result.
REQ-014 out_valid / out_ready  out / in  1 / 1  downstream handshake.
REQ-015 out_pc, out_op1, out_op2  out  XLEN  registered PC and operands.
REQ-016 out_aluop, out_alusel  out  AluOpBus / AluSelBus  existing EXE_* encodings.
REQ-017 out_waddr  out  REGADDR_W; out_we  out  1; out_illegal  out  1.

Function
REQ-018 Decode: LUI, AUIPC, OP-IMM, OP per existing RV32I mapping (LUI op1={imm,12'b0}, op2=0; AUIPC op2=pc; ADDI/SLTI/SLTIU sign-extend; XORI/ORI/ANDI zero-extend; shifts op2=shamt).
REQ-019 Unsupported opcode/funct3/funct7: out_illegal=1, out_we=0, aluop=EXE_NOP_OP, alusel=EXE_RES_NOP, out_valid still asserted.
REQ-020 rd=0 SHALL force out_we=0.
REQ-021 Read address for an unused source SHALL be 0; source address 0 yields operand 0 regardless of bypass or regfile.
REQ-022 Bypass priority per used source (FWD_EN=1): EX match (ex_we, ex_waddr==rs, rs!=0, !ex_is_load) > MEM match (mem_we, mem_waddr==rs, rs!=0) > regfile.
REQ-023 Load-use hazard: ex_is_load & ex_we & ex_waddr!=0 & ex_waddr equals a used source -> in_ready=0 that cycle.
REQ-024 in_ready = !hazard & (!out_valid | out_ready); combinational, no dependence on in_valid.
REQ-025 Accept = in_valid & in_ready & !flush; on accept, all out_* register decoded fields and operands next edge (latency 1 cycle).
REQ-026 out_valid: set on accept; cleared on out_ready & no accept; held with all out_* stable while out_valid & !out_ready.
REQ-027 Back-to-back: out_valid & out_ready & accept same cycle -> new instruction replaces old, out_valid stays 1, no bubble.
REQ-028 flush=1: out_valid cleared next edge, incoming instruction dropped regardless of in_valid/in_ready; flush dominates accept.
REQ-029 Operands captured at accept only; later bypass changes do not alter held outputs.
REQ-030 Hazard with out_valid & out_ready: held instruction retires, out_valid=0 next cycle (bubble).

Reset
REQ-031 rst=0: out_valid=0, out_pc=0, out_op1=0, out_op2=0, out_aluop=EXE_NOP_OP, out_alusel=EXE_RES_NOP, out_waddr=0, out_we=0, out_illegal=0, asynchronously.
REQ-032 rst=0 mid-transaction discards held instruction; in_ready=0 while rst=0; first accept possible on first edge after rst=1.

Verification
REQ-033 ADDI x1,x2,-1 with reg2 data 5, no bypass -> next cycle out_valid=1, op1=5, op2=32'hFFFFFFFF, aluop=ADD, waddr=1, we=1.
REQ-034 ADD x3,x1,x2 with ex_we,ex_waddr=1,ex_wdata=7 and mem_we,mem_waddr=1,mem_wdata=9, x2 regfile 4 -> op1=7, op2=4.
REQ-035 SUB x3,x1,x2 with ex_is_load,ex_we,ex_waddr=2 -> in_ready=0; drop ex_is_load next cycle -> accepted, op2 from MEM/regfile.
REQ-036 out_ready=0 for 3 cycles with in_valid=1 -> out_* unchanged, in_ready=0; out_ready=1 -> next instruction accepted without bubble.
REQ-037 Opcode 7'b1111111 -> out_illegal=1, out_we=0; ADDI x0,x0,1 -> out_we=0; LUI x5,0x12345 -> op1=32'h12345000.
REQ-038 flush and rst=0 asserted while out_valid=1 & out_ready=0 -> out_valid=0 (next edge / immediately), incoming dropped.

Source files
------------

// File: rtl/id_pipe.sv
// Instruction-decode stage: decodes RV32I LUI/AUIPC/OP-IMM/OP, reads and bypasses
// source operands, and holds the result in a valid/ready output register.
module id_pipe #(
  parameter  int unsigned XLEN      = 32,
  parameter  int unsigned REGADDR_W = 5,
  parameter  int unsigned FWD_EN    = 1,
  localparam int unsigned ALUOP_W   = 8,
  localparam int unsigned ALUSEL_W  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [31:0]          in_inst,
  output logic [REGADDR_W-1:0] reg1_raddr_o,
  output logic [REGADDR_W-1:0] reg2_raddr_o,
  input  logic [XLEN-1:0]      reg1_rdata_i,
  input  logic [XLEN-1:0]      reg2_rdata_i,
  input  logic                 ex_we,
  input  logic                 ex_is_load,
  input  logic [REGADDR_W-1:0] ex_waddr,
  input  logic [XLEN-1:0]      ex_wdata,
  input  logic                 mem_we,
  input  logic [REGADDR_W-1:0] mem_waddr,
  input  logic [XLEN-1:0]      mem_wdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_op1,
  output logic [XLEN-1:0]      out_op2,
  output logic [ALUOP_W-1:0]   out_aluop,
  output logic [ALUSEL_W-1:0]  out_alusel,
  output logic [REGADDR_W-1:0] out_waddr,
  output logic                 out_we,
  output logic                 out_illegal
);

  localparam logic [ALUOP_W-1:0] EXE_NOP_OP  = 8'h00;
  localparam logic [ALUOP_W-1:0] EXE_ADD_OP  = 8'h20;
  localparam logic [ALUOP_W-1:0] EXE_SUB_OP  = 8'h22;
  localparam logic [ALUOP_W-1:0] EXE_AND_OP  = 8'h24;
  localparam logic [ALUOP_W-1:0] EXE_OR_OP   = 8'h25;
  localparam logic [ALUOP_W-1:0] EXE_XOR_OP  = 8'h26;
  localparam logic [ALUOP_W-1:0] EXE_SLT_OP  = 8'h2A;
  localparam logic [ALUOP_W-1:0] EXE_SLTU_OP = 8'h2B;
  localparam logic [ALUOP_W-1:0] EXE_SLL_OP  = 8'h7C;
  localparam logic [ALUOP_W-1:0] EXE_SRL_OP  = 8'h02;
  localparam logic [ALUOP_W-1:0] EXE_SRA_OP  = 8'h03;

  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP        = 3'b000;
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC      = 3'b001;
  localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT      = 3'b010;
  localparam logic [ALUSEL_W-1:0] EXE_RES_ARITHMETIC = 3'b100;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef enum logic [1:0] {OP2_ZERO, OP2_REG, OP2_IMM, OP2_PC} op2_sel_e;

  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [6:0]           funct7;
  logic [REGADDR_W-1:0] rd, rs1, rs2;
  logic [XLEN-1:0]      imm_u, imm_s, imm_z, imm_sh;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];
  assign rd     = REGADDR_W'(in_inst[11:7]);
  assign rs1    = REGADDR_W'(in_inst[19:15]);
  assign rs2    = REGADDR_W'(in_inst[24:20]);
  assign imm_u  = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign imm_s  = XLEN'($signed(in_inst[31:20]));
  assign imm_z  = XLEN'(in_inst[31:20]);
  assign imm_sh = XLEN'(in_inst[24:20]);

  logic                d_use1, d_use2, d_we, d_ill, d_op1_imm;
  logic [ALUOP_W-1:0]  d_aluop;
  logic [ALUSEL_W-1:0] d_alusel;
  logic [XLEN-1:0]     d_imm;
  op2_sel_e            d_op2_sel;

  // Instruction decode; an illegal encoding squashes every side effect
  always_comb begin
    d_use1    = 1'b0;
    d_use2    = 1'b0;
    d_we      = 1'b0;
    d_ill     = 1'b0;
    d_op1_imm = 1'b0;
    d_aluop   = EXE_NOP_OP;
    d_alusel  = EXE_RES_NOP;
    d_imm     = '0;
    d_op2_sel = OP2_ZERO;
    case (opcode)
      OPC_LUI: begin
        d_we = 1'b1; d_op1_imm = 1'b1; d_imm = imm_u;
        d_aluop = EXE_OR_OP; d_alusel = EXE_RES_LOGIC;
      end
      OPC_AUIPC: begin
        d_we = 1'b1; d_op1_imm = 1'b1; d_imm = imm_u; d_op2_sel = OP2_PC;
        d_aluop = EXE_ADD_OP; d_alusel = EXE_RES_ARITHMETIC;
      end
      OPC_OPIMM: begin
        d_use1 = 1'b1; d_we = 1'b1; d_op2_sel = OP2_IMM; d_imm = imm_s;
        case (funct3)
          3'b000: begin d_aluop = EXE_ADD_OP;  d_alusel = EXE_RES_ARITHMETIC; end
          3'b010: begin d_aluop = EXE_SLT_OP;  d_alusel = EXE_RES_ARITHMETIC; end
          3'b011: begin d_aluop = EXE_SLTU_OP; d_alusel = EXE_RES_ARITHMETIC; end
          3'b100: begin d_aluop = EXE_XOR_OP;  d_alusel = EXE_RES_LOGIC; d_imm = imm_z; end
          3'b110: begin d_aluop = EXE_OR_OP;   d_alusel = EXE_RES_LOGIC; d_imm = imm_z; end
          3'b111: begin d_aluop = EXE_AND_OP;  d_alusel = EXE_RES_LOGIC; d_imm = imm_z; end
          3'b001: begin
            d_imm = imm_sh; d_alusel = EXE_RES_SHIFT;
            if (funct7 == F7_BASE) d_aluop = EXE_SLL_OP;
            else                   d_ill = 1'b1;
          end
          default: begin
            d_imm = imm_sh; d_alusel = EXE_RES_SHIFT;
            if      (funct7 == F7_BASE) d_aluop = EXE_SRL_OP;
            else if (funct7 == F7_ALT)  d_aluop = EXE_SRA_OP;
            else                        d_ill = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        d_use1 = 1'b1; d_use2 = 1'b1; d_we = 1'b1; d_op2_sel = OP2_REG;
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  begin d_aluop = EXE_ADD_OP;  d_alusel = EXE_RES_ARITHMETIC; end
            3'b001:  begin d_aluop = EXE_SLL_OP;  d_alusel = EXE_RES_SHIFT; end
            3'b010:  begin d_aluop = EXE_SLT_OP;  d_alusel = EXE_RES_ARITHMETIC; end
            3'b011:  begin d_aluop = EXE_SLTU_OP; d_alusel = EXE_RES_ARITHMETIC; end
            3'b100:  begin d_aluop = EXE_XOR_OP;  d_alusel = EXE_RES_LOGIC; end
            3'b101:  begin d_aluop = EXE_SRL_OP;  d_alusel = EXE_RES_SHIFT; end
            3'b110:  begin d_aluop = EXE_OR_OP;   d_alusel = EXE_RES_LOGIC; end
            default: begin d_aluop = EXE_AND_OP;  d_alusel = EXE_RES_LOGIC; end
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          d_aluop = EXE_SUB_OP; d_alusel = EXE_RES_ARITHMETIC;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          d_aluop = EXE_SRA_OP; d_alusel = EXE_RES_SHIFT;
        end else begin
          d_ill = 1'b1;
        end
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_use1    = 1'b0;
      d_use2    = 1'b0;
      d_we      = 1'b0;
      d_op1_imm = 1'b0;
      d_aluop   = EXE_NOP_OP;
      d_alusel  = EXE_RES_NOP;
      d_op2_sel = OP2_ZERO;
    end
  end

  assign reg1_raddr_o = d_use1 ? rs1 : '0;
  assign reg2_raddr_o = d_use2 ? rs2 : '0;

  logic [XLEN-1:0] src1, src2, op1, op2;

  // Source operands: EX result beats MEM result beats regfile; x0 always reads zero
  always_comb begin
    src1 = '0;
    if (d_use1 && rs1 != '0) begin
      if (FWD_EN != 0 && ex_we && !ex_is_load && ex_waddr == rs1) src1 = ex_wdata;
      else if (FWD_EN != 0 && mem_we && mem_waddr == rs1)         src1 = mem_wdata;
      else                                                        src1 = reg1_rdata_i;
    end
  end

  always_comb begin
    src2 = '0;
    if (d_use2 && rs2 != '0) begin
      if (FWD_EN != 0 && ex_we && !ex_is_load && ex_waddr == rs2) src2 = ex_wdata;
      else if (FWD_EN != 0 && mem_we && mem_waddr == rs2)         src2 = mem_wdata;
      else                                                        src2 = reg2_rdata_i;
    end
  end

  always_comb begin
    op1 = d_op1_imm ? d_imm : src1;
    case (d_op2_sel)
      OP2_REG: op2 = src2;
      OP2_IMM: op2 = d_imm;
      OP2_PC:  op2 = in_pc;
      default: op2 = '0;
    endcase
  end

  logic hazard, accept;

  // A load in EX cannot be bypassed, so a dependent instruction must wait
  assign hazard = ex_is_load && ex_we && ex_waddr != '0 &&
                  ((d_use1 && ex_waddr == rs1) || (d_use2 && ex_waddr == rs2));
  assign in_ready = rst && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_op1     <= '0;
      out_op2     <= '0;
      out_aluop   <= EXE_NOP_OP;
      out_alusel  <= EXE_RES_NOP;
      out_waddr   <= '0;
      out_we      <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_op1     <= op1;
      out_op2     <= op2;
      out_aluop   <= d_aluop;
      out_alusel  <= d_alusel;
      out_waddr   <= d_ill ? '0 : rd;
      out_we      <= d_we && rd != '0;
      out_illegal <= d_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_pipe.sv
// Directed bench for id_pipe: expected decode results are queued at issue and
// compared as each instruction leaves through the out_valid/out_ready handshake.
module tb_id_pipe;

  localparam logic [7:0] OP_NOP = 8'h00, OP_ADD = 8'h20, OP_SUB = 8'h22, OP_AND = 8'h24;
  localparam logic [7:0] OP_OR = 8'h25, OP_XOR = 8'h26, OP_SLTU = 8'h2B;
  localparam logic [7:0] OP_SLL = 8'h7C, OP_SRA = 8'h03;
  localparam logic [2:0] S_NOP = 3'b000, S_LOG = 3'b001, S_SH = 3'b010, S_AR = 3'b100;

  typedef struct packed {
    logic [31:0] pc, op1, op2;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [4:0]  waddr;
    logic        we, ill;
  } exp_t;

  logic        clk = 1'b0, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_inst, ex_wdata, mem_wdata, reg1_rdata_i, reg2_rdata_i;
  logic [4:0]  reg1_raddr_o, reg2_raddr_o, ex_waddr, mem_waddr, out_waddr;
  logic        ex_we, ex_is_load, mem_we, out_we, out_illegal;
  logic [31:0] out_pc, out_op1, out_op2;
  logic [7:0]  out_aluop;
  logic [2:0]  out_alusel;
  logic [31:0] rf [32];

  int   errors = 0, checks = 0, pushed = 0, dropped = 0, retired = 0;
  exp_t sb[$];
  exp_t mon_e;

  id_pipe dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .reg1_raddr_o(reg1_raddr_o), .reg2_raddr_o(reg2_raddr_o),
    .reg1_rdata_i(reg1_rdata_i), .reg2_rdata_i(reg2_rdata_i), .ex_we(ex_we),
    .ex_is_load(ex_is_load), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_op1(out_op1), .out_op2(out_op2), .out_aluop(out_aluop),
    .out_alusel(out_alusel), .out_waddr(out_waddr), .out_we(out_we), .out_illegal(out_illegal)
  );

  assign reg1_rdata_i = rf[reg1_raddr_o];
  assign reg2_rdata_i = rf[reg2_raddr_o];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] op1,
                              input logic [31:0] op2, input logic [7:0] aluop,
                              input logic [2:0] alusel, input logic [4:0] waddr,
                              input logic we, input logic ill);
    mk = '{pc: pc, op1: op1, op2: op2, aluop: aluop, alusel: alusel,
           waddr: waddr, we: we, ill: ill};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    itype = {imm, rs1, f3, rd, 7'h13};
  endfunction

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    rtype = {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  // Present an instruction that must be accepted at the next edge
  task automatic put(input logic [31:0] pc, input logic [31:0] inst, input exp_t e);
    in_valid = 1'b1; in_pc = pc; in_inst = inst;
    sb.push_back(e);
    pushed++;
    #1;
    chk("in_ready", 64'(in_ready), 64'(1'b1));
  endtask

  task automatic go();
    @(posedge clk); #1;
    chk("out_valid_after_accept", 64'(out_valid), 64'(1'b1));
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_pc", 64'(out_pc), 64'(0));
    chk("rst_out_op1", 64'(out_op1), 64'(0));
    chk("rst_out_op2", 64'(out_op2), 64'(0));
    chk("rst_out_aluop", 64'(out_aluop), 64'(OP_NOP));
    chk("rst_out_alusel", 64'(out_alusel), 64'(S_NOP));
    chk("rst_out_waddr", 64'(out_waddr), 64'(0));
    chk("rst_out_we", 64'(out_we), 64'(0));
    chk("rst_out_illegal", 64'(out_illegal), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
  endtask

  // Scoreboard: each handshake on the output retires the oldest expectation
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_underflow: observed retire at pc=%h expected none", out_pc);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        retired++;
        chk("pc", 64'(out_pc), 64'(mon_e.pc));
        chk("op1", 64'(out_op1), 64'(mon_e.op1));
        chk("op2", 64'(out_op2), 64'(mon_e.op2));
        chk("aluop", 64'(out_aluop), 64'(mon_e.aluop));
        chk("alusel", 64'(out_alusel), 64'(mon_e.alusel));
        chk("waddr", 64'(out_waddr), 64'(mon_e.waddr));
        chk("we", 64'(out_we), 64'(mon_e.we));
        chk("illegal", 64'(out_illegal), 64'(mon_e.ill));
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_pc = '0; in_inst = '0; out_ready = 1'b1;
    ex_we = 1'b0; ex_is_load = 1'b0; ex_waddr = '0; ex_wdata = '0;
    mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
    #2 rst = 1'b0;
    #1 chk_reset_outputs();
    @(posedge clk); #1;
    chk("rst_hold_valid", 64'(out_valid), 64'(0));
    chk("rst_hold_in_ready", 64'(in_ready), 64'(0));
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;

    // ADDI x1,x2,-1 with no bypass; x2 only source, so read port 2 idles at 0
    rf[2] = 32'd5;
    put(32'h100, itype(12'hFFF, 5'd2, 3'b000, 5'd1),
        mk(32'h100, 32'd5, 32'hFFFF_FFFF, OP_ADD, S_AR, 5'd1, 1'b1, 1'b0));
    chk("raddr1_used", 64'(reg1_raddr_o), 64'(5'd2));
    chk("raddr2_unused", 64'(reg2_raddr_o), 64'(5'd0));
    go();

    // ADD x3,x1,x2: EX beats MEM on x1, x2 from regfile
    rf[1] = 32'hAA; rf[2] = 32'd4;
    ex_we = 1'b1; ex_waddr = 5'd1; ex_wdata = 32'd7;
    mem_we = 1'b1; mem_waddr = 5'd1; mem_wdata = 32'd9;
    put(32'h104, rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd3),
        mk(32'h104, 32'd7, 32'd4, OP_ADD, S_AR, 5'd3, 1'b1, 1'b0));
    go();

    // OR x4,x1,x2: MEM beats regfile on x2
    rf[1] = 32'h11; ex_we = 1'b0; mem_waddr = 5'd2; mem_wdata = 32'h55;
    put(32'h108, rtype(7'h00, 5'd2, 5'd1, 3'b110, 5'd4),
        mk(32'h108, 32'h11, 32'h55, OP_OR, S_LOG, 5'd4, 1'b1, 1'b0));
    go();

    // ADD x5,x0,x2: x0 reads zero even with bypass and regfile aimed at it
    rf[0] = 32'h77; ex_we = 1'b1; ex_waddr = 5'd0; ex_wdata = 32'hDEAD;
    mem_waddr = 5'd0; mem_wdata = 32'hBEEF;
    put(32'h10C, rtype(7'h00, 5'd2, 5'd0, 3'b000, 5'd5),
        mk(32'h10C, 32'd0, 32'd4, OP_ADD, S_AR, 5'd5, 1'b1, 1'b0));
    go();

    // SUB x3,x1,x2 behind a load to x2: stall, previous retires into a bubble
    rf[1] = 32'd10; mem_we = 1'b0;
    ex_is_load = 1'b1; ex_we = 1'b1; ex_waddr = 5'd2; ex_wdata = 32'h999;
    in_valid = 1'b1; in_pc = 32'h110; in_inst = rtype(7'h20, 5'd2, 5'd1, 3'b000, 5'd3);
    #1 chk("load_use_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    chk("load_use_bubble", 64'(out_valid), 64'(0));
    ex_is_load = 1'b0; ex_we = 1'b0; mem_we = 1'b1; mem_waddr = 5'd2; mem_wdata = 32'h30;
    put(32'h110, rtype(7'h20, 5'd2, 5'd1, 3'b000, 5'd3),
        mk(32'h110, 32'd10, 32'h30, OP_SUB, S_AR, 5'd3, 1'b1, 1'b0));
    go();
    mem_we = 1'b0;

    // XORI held for 3 stalled cycles while the bypass changes under it
    put(32'h114, itype(12'h800, 5'd1, 3'b100, 5'd6),
        mk(32'h114, 32'd10, 32'h800, OP_XOR, S_LOG, 5'd6, 1'b1, 1'b0));
    go();
    out_ready = 1'b0; ex_we = 1'b1; ex_waddr = 5'd1; ex_wdata = 32'h123;
    in_valid = 1'b1; in_pc = 32'h118; in_inst = itype(12'h0F0, 5'd2, 3'b111, 5'd7);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      chk("stall_valid", 64'(out_valid), 64'(1));
      chk("stall_pc", 64'(out_pc), 64'(32'h114));
      chk("stall_op1", 64'(out_op1), 64'(32'd10));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    put(32'h118, itype(12'h0F0, 5'd2, 3'b111, 5'd7),
        mk(32'h118, 32'd4, 32'hF0, OP_AND, S_LOG, 5'd7, 1'b1, 1'b0));
    go();
    chk("no_bubble_pc", 64'(out_pc), 64'(32'h118));
    ex_we = 1'b0;

    // Decode corners, issued back to back
    put(32'h200, 32'h0000_007F, mk(32'h200, 0, 0, OP_NOP, S_NOP, 5'd0, 1'b0, 1'b1)); go();
    put(32'h204, itype(12'd1, 5'd0, 3'b000, 5'd0),
        mk(32'h204, 0, 32'd1, OP_ADD, S_AR, 5'd0, 1'b0, 1'b0)); go();
    put(32'h208, {20'h12345, 5'd5, 7'h37},
        mk(32'h208, 32'h1234_5000, 0, OP_OR, S_LOG, 5'd5, 1'b1, 1'b0)); go();
    put(32'h20C, {20'h00001, 5'd8, 7'h17},
        mk(32'h20C, 32'h1000, 32'h20C, OP_ADD, S_AR, 5'd8, 1'b1, 1'b0)); go();
    put(32'h210, itype({7'h20, 5'd3}, 5'd1, 3'b101, 5'd9),
        mk(32'h210, 32'd10, 32'd3, OP_SRA, S_SH, 5'd9, 1'b1, 1'b0)); go();
    put(32'h214, rtype(7'h01, 5'd2, 5'd1, 3'b000, 5'd10),
        mk(32'h214, 0, 0, OP_NOP, S_NOP, 5'd0, 1'b0, 1'b1)); go();
    put(32'h218, itype(12'hFFE, 5'd1, 3'b011, 5'd11),
        mk(32'h218, 32'd10, 32'hFFFF_FFFE, OP_SLTU, S_AR, 5'd11, 1'b1, 1'b0)); go();
    put(32'h21C, rtype(7'h00, 5'd2, 5'd1, 3'b001, 5'd12),
        mk(32'h21C, 32'd10, 32'd4, OP_SLL, S_SH, 5'd12, 1'b1, 1'b0)); go();

    // Flush kills a stalled instruction and drops the incoming one
    put(32'h300, itype(12'd1, 5'd1, 3'b110, 5'd13),
        mk(32'h300, 32'd10, 32'd1, OP_OR, S_LOG, 5'd13, 1'b1, 1'b0));
    go();
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk("flush_pre_valid", 64'(out_valid), 64'(1));
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h304; in_inst = itype(12'hFFF, 5'd2, 3'b000, 5'd1);
    @(posedge clk); #1;
    chk("flush_kills_held", 64'(out_valid), 64'(0));
    sb.delete(sb.size() - 1); dropped++;
    out_ready = 1'b1;
    #1 chk("flush_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    chk("flush_drops_incoming", 64'(out_valid), 64'(0));
    flush = 1'b0; in_valid = 1'b0;

    // Asynchronous reset mid-transaction, then accept on first edge after release
    put(32'h400, itype(12'h0F0, 5'd2, 3'b111, 5'd7),
        mk(32'h400, 32'd4, 32'hF0, OP_AND, S_LOG, 5'd7, 1'b1, 1'b0));
    go();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h404; in_inst = itype(12'hFFF, 5'd2, 3'b000, 5'd1);
    #2 rst = 1'b0;
    #1 chk_reset_outputs();
    sb.delete(sb.size() - 1); dropped++;
    @(posedge clk); #1;
    chk("rst_mid_valid", 64'(out_valid), 64'(0));
    rst = 1'b1; out_ready = 1'b1;
    put(32'h404, itype(12'hFFF, 5'd2, 3'b000, 5'd1),
        mk(32'h404, 32'd4, 32'hFFFF_FFFF, OP_ADD, S_AR, 5'd1, 1'b1, 1'b0));
    go();

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'(0));
    chk("retired_count", 64'(retired), 64'(pushed - dropped));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
